fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, meaning PC and memory address width; legal range 32..64.
REQ-002 Parameter DEPTH, default 4, meaning instruction queue entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 Port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  meaning reset, asynchronous and active-high.
REQ-006 Port mem_req  out  1  meaning a fetch request is pending.
REQ-007 Port mem_addr  out  ADDR_W  meaning the fetch address, word aligned.
REQ-008 Port mem_ack  in  1  meaning mem_rdata is valid this cycle and completes the request.
REQ-009 Port mem_rdata  in  32  meaning the fetched instruction word.
REQ-010 Port instr_valid  out  1  meaning the queue head is valid.
REQ-011 Port instr_ready  in  1  meaning the consumer accepts the head this cycle.
REQ-012 Port instr_out  out  32  meaning the head instruction.
REQ-013 Port instr_pc  out  ADDR_W  meaning the fetch address of the head instruction.
REQ-014 Port redir_valid  in  1  meaning change the fetch path this cycle.
REQ-015 Port redir_mode  in  2  meaning the target kind: 00 branch, 01 jump, 10 register, 11 reserved.
REQ-016 Port redir_pc  in  ADDR_W  meaning the PC of the redirecting instruction.
REQ-017 Port redir_imm  in  16  meaning the branch offset in words.
REQ-018 Port redir_jaddr  in  26  meaning the jump target field.
REQ-019 Port redir_reg  in  ADDR_W  meaning the register-indirect target.
REQ-020 Port count  out  clog2(DEPTH)+1  meaning the current queue occupancy.

Function
REQ-021 Targets SHALL be computed from p4 = redir_pc+4 as follows: branch = p4 + (sign-extended redir_imm << 2), modulo 2^ADDR_W.
REQ-022 Jump target SHALL be {p4[ADDR_W-1:28], redir_jaddr, 2'b00}.
REQ-023 Register target SHALL be {redir_reg[ADDR_W-1:2], 2'b00}.
REQ-024 Mode 11 SHALL be ignored entirely (no flush, no PC change).
REQ-025 The FSM SHALL have three states: RUN (no request), WAIT (request outstanding), DISCARD (request outstanding, response to be dropped).
REQ-026 mem_req SHALL be registered and SHALL equal 1 exactly in WAIT and DISCARD.
REQ-027 mem_addr SHALL be held stable from request start until mem_ack.
REQ-028 RUN->WAIT SHALL occur when count < DEPTH and redir_valid=0; mem_addr SHALL be latched from fetch_pc.
REQ-029 WAIT with mem_ack and no redirect SHALL push {mem_rdata, mem_addr} into the queue, set fetch_pc = mem_addr+4, and go to RUN.
REQ-030 Maximum throughput SHALL be 1 instruction per 2 cycles; no new request SHALL be issued in the ack cycle.
REQ-031 Any valid redirect SHALL empty the queue and set fetch_pc = target in the same edge.
REQ-032 A redirect in WAIT without mem_ack SHALL go to DISCARD, keep mem_req high, and keep mem_addr unchanged.
REQ-033 A redirect in WAIT coincident with mem_ack SHALL drop the response and go to RUN.
REQ-034 DISCARD on mem_ack SHALL drop the data and go to RUN.
REQ-035 A further redirect in DISCARD SHALL only update fetch_pc.
REQ-036 The queue SHALL be a circular FIFO with DEPTH entries; read/write pointers SHALL wrap modulo DEPTH.
REQ-037 instr_valid SHALL equal (count != 0); a pop occurs on instr_valid & instr_ready.
REQ-038 A simultaneous push and pop SHALL leave count unchanged.
REQ-039 A redirect coincident with a pop SHALL take priority: count=0 next cycle.
REQ-040 Requests SHALL NOT be issued while count == DEPTH (full); issue SHALL resume the cycle after a pop.
REQ-041 mem_ack in RUN SHALL be ignored.

Reset
REQ-042 While reset=1 the block SHALL force: state RUN, fetch_pc = RESET_PC, count = 0, pointers = 0, mem_req = 0, mem_addr = RESET_PC, instr_valid = 0.
REQ-043 Reset asserted mid-request SHALL abandon the request; mem_ack arriving in RUN after reset SHALL be ignored.
REQ-044 The first request SHALL be issued with mem_req=1 on the second rising edge after reset deasserts; the address SHALL be RESET_PC.

Verification
REQ-045 Sequential fetch: RESET_PC=0, ack one cycle after each request, instr_ready=1 -> instr_pc = 0, 4, 8, 12 in order, and instr_out matches memory.
REQ-046 Full queue: DEPTH=4, instr_ready=0 -> count reaches 4 and mem_req stays 0; one pop -> a request follows on the next cycle.
REQ-047 Branch: redir_pc=0x100, imm=0xFFFE, mode 00 -> queue flushed and the next mem_addr = 0xFC.
REQ-048 Jump and register: redir_pc=0x1000_0000, jaddr=0x10 -> 0x1000_0040; redir_reg=0x2003 -> 0x2000.
REQ-049 Discard: redirect while WAIT, ack 3 cycles later -> data is not queued and the next request goes to the redirect target.
REQ-050 Reset mid-WAIT: reset pulse with mem_req=1 -> all outputs return to their reset values asynchronously, and the following ack is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// circular instruction queue, with branch/jump/register redirects.
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     redir_valid,
    input  logic [1:0]               redir_mode,
    input  logic [ADDR_W-1:0]        redir_pc,
    input  logic [15:0]              redir_imm,
    input  logic [25:0]              redir_jaddr,
    input  logic [ADDR_W-1:0]        redir_reg,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_t;

    state_t            state;
    logic              boot;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] p4;
    logic [ADDR_W-1:0] target;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [31:0]       q_instr [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic              redir;
    logic              pop;
    logic              push;

    assign p4 = redir_pc + ADDR_W'(4);

    always_comb begin
        target = p4;
        unique case (redir_mode)
            2'b00: target = p4 + {{(ADDR_W-18){redir_imm[15]}},
                                  redir_imm, 2'b00};
            2'b01: target = {p4[ADDR_W-1:28], redir_jaddr, 2'b00};
            2'b10: target = redir_reg & ~ADDR_W'(3);
            default: target = p4;
        endcase
    end

    // Reserved mode 11 behaves as if no redirect was presented.
    assign redir = redir_valid && (redir_mode != 2'b11);
    assign instr_valid = (count != '0);
    assign pop = instr_valid && instr_ready;
    assign push = (state == WAIT) && mem_ack && !redir;
    assign instr_out = q_instr[rd_ptr];
    assign instr_pc = q_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= mem_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            boot     <= 1'b1;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            boot <= 1'b0;
            if (redir) begin
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= target;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
            end
            // The boot cycle delays the first request by one edge.
            unique case (state)
                RUN: begin
                    if (!redir && !boot && count != FULL) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc & ~ADDR_W'(3);
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state   <= RUN;
                        mem_req <= 1'b0;
                        if (!redir)
                            fetch_pc <= mem_addr + ADDR_W'(4);
                    end else if (redir) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state   <= RUN;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= RUN;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule
